link_vq_multi: RTL and testbench

- N-list virtual queue. NUM_LISTS independent FIFOs share one DEPTH-entry data store, with linked-list pointers per entry.
- Free slots are kept on an internal free list, so writers do not supply a slot index.
- Adds two things the 2-list design lacks: a per-list occupancy count, and a single-cycle flush of any one list.
- Sits between the ingress classifier and the per-class schedulers in the queueing path.

---
 rtl/link_vq_pkg.sv | 19 +
 rtl/link_vq_list_ctrl.sv | 64 ++++++
 rtl/link_vq_multi.sv | 126 ++++++++++++
 tb/tb_link_vq_multi.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/link_vq_pkg.sv
// Shared definitions for the linked-list virtual queue: default sizing and
// the pointer and count width helpers.
package link_vq_pkg;

  localparam int DEF_DATAWIDTH = 128;
  localparam int DEF_DEPTH     = 32;
  localparam int DEF_NUM_LISTS = 4;

  // Width of a node index into a DEPTH-entry store.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Width of an occupancy count that must be able to hold DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/link_vq_list_ctrl.sv
// Head/tail/count bookkeeping for one list of the virtual queue. The top
// level owns the node store and the next pointers.
module link_vq_list_ctrl
  import link_vq_pkg::*;
#(
  parameter  int DEPTH = DEF_DEPTH,
  localparam int PW    = ptr_w(DEPTH),
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [PW-1:0] alloc_node,
  input  logic [PW-1:0] head_next,
  output logic [PW-1:0] head,
  output logic [PW-1:0] tail,
  output logic [CW-1:0] count
);

  typedef struct packed {
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
  } list_state_t;

  list_state_t st;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= '0;
    end else if (flush && (st.count != '0)) begin
      // The nodes themselves are handed to the free list by the top level.
      st.count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (st.count == '0) st.head <= alloc_node;
          st.tail  <= alloc_node;
          st.count <= st.count + CW'(1);
        end
        2'b01: begin
          st.head  <= head_next;
          st.count <= st.count - CW'(1);
        end
        2'b11: begin
          // With a single entry the popped node is also the tail, so the new
          // node becomes the whole list.
          st.head <= (st.count == CW'(1)) ? alloc_node : head_next;
          st.tail <= alloc_node;
        end
        default: ;
      endcase
    end
  end

  assign head  = st.head;
  assign tail  = st.tail;
  assign count = st.count;

endmodule

// File: rtl/link_vq_multi.sv
// N-list virtual queue: NUM_LISTS FIFOs threaded through one shared node
// store, with a free list, per-list occupancy and single-cycle list flush.
module link_vq_multi
  import link_vq_pkg::*;
#(
  parameter  int DATAWIDTH = DEF_DATAWIDTH,
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int NUM_LISTS = DEF_NUM_LISTS,
  localparam int PW        = ptr_w(DEPTH),
  localparam int CW        = cnt_w(DEPTH),
  localparam int LW        = $clog2(NUM_LISTS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_vld,
  output logic                    wr_rdy,
  input  logic [LW-1:0]           wr_list,
  input  logic [DATAWIDTH-1:0]    wr_data,
  input  logic [LW-1:0]           rd_list,
  output logic                    rd_vld,
  input  logic                    rd_rdy,
  output logic [DATAWIDTH-1:0]    rd_data,
  input  logic                    flush_vld,
  input  logic [LW-1:0]           flush_list,
  output logic [NUM_LISTS-1:0]    list_empty,
  output logic [NUM_LISTS*CW-1:0] list_count,
  output logic [CW-1:0]           free_count
);

  logic [DATAWIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]        next_ptr [DEPTH];

  logic [PW-1:0] free_head, free_tail;

  logic [PW-1:0] lst_head  [NUM_LISTS];
  logic [PW-1:0] lst_tail  [NUM_LISTS];
  logic [CW-1:0] lst_count [NUM_LISTS];

  logic [NUM_LISTS-1:0] push_sel, pop_sel, flush_sel;

  logic          wr_fire, rd_fire, flush_fire;
  logic          pop_link;
  logic [PW-1:0] pop_node;

  assign wr_rdy     = (free_count != '0) && !flush_vld;
  assign rd_vld     = (lst_count[rd_list] != '0) && !flush_vld;
  assign rd_data    = data_mem[lst_head[rd_list]];
  assign wr_fire    = wr_vld && wr_rdy;
  assign rd_fire    = rd_vld && rd_rdy;
  assign flush_fire = flush_vld && (lst_count[flush_list] != '0);
  assign pop_node   = lst_head[rd_list];

  // A popped node is linked behind free_tail only while some other node is
  // still free after this cycle's allocation; otherwise free_tail is stale
  // and may point into a live list, so the popped node starts a fresh free list.
  assign pop_link = rd_fire && (free_count > CW'(wr_fire));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push_sel  = '0;
    pop_sel   = '0;
    flush_sel = '0;
    for (int i = 0; i < NUM_LISTS; i++) begin
      push_sel[i]  = wr_fire   && (int'(wr_list)    == i);
      pop_sel[i]   = rd_fire   && (int'(rd_list)    == i);
      flush_sel[i] = flush_vld && (int'(flush_list) == i);
    end
  end

  for (genvar g = 0; g < NUM_LISTS; g++) begin : g_list
    link_vq_list_ctrl #(.DEPTH(DEPTH)) u_ctrl (
      .clk        (clk),
      .reset      (reset),
      .push       (push_sel[g]),
      .pop        (pop_sel[g]),
      .flush      (flush_sel[g]),
      .alloc_node (free_head),
      .head_next  (next_ptr[lst_head[g]]),
      .head       (lst_head[g]),
      .tail       (lst_tail[g]),
      .count      (lst_count[g])
    );
    assign list_count[g*CW +: CW] = lst_count[g];
    assign list_empty[g]          = (lst_count[g] == '0);
  end

  // NOTE: the payload store carries no reset; a slot is only ever read after
  // a write has filled it, and leaving it reset-free lets it map to RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) data_mem[free_head] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) next_ptr[i] <= PW'((i + 1) % DEPTH);
    end else if (flush_fire) begin
      if (free_count != '0) next_ptr[free_tail] <= lst_head[flush_list];
    end else begin
      if (wr_fire && (lst_count[wr_list] != '0)) next_ptr[lst_tail[wr_list]] <= free_head;
      if (pop_link) next_ptr[free_tail] <= pop_node;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_head  <= '0;
      free_tail  <= PW'(DEPTH - 1);
      free_count <= CW'(DEPTH);
    end else if (flush_fire) begin
      if (free_count == '0) free_head <= lst_head[flush_list];
      free_tail  <= lst_tail[flush_list];
      free_count <= free_count + lst_count[flush_list];
    end else begin
      if (wr_fire) free_head <= next_ptr[free_head];
      if (rd_fire) begin
        free_tail <= pop_node;
        if (!pop_link) free_head <= pop_node;
      end
      free_count <= free_count - CW'(wr_fire) + CW'(rd_fire);
    end
  end

  wr_list_in_range : assert property (@(posedge clk) disable iff (reset)
    wr_vld |-> (int'(wr_list) < NUM_LISTS));

endmodule

// File: tb/tb_link_vq_multi.sv
// Self-checking bench for link_vq_multi (DEPTH=8, NUM_LISTS=4) built around
// per-list scoreboard queues.
module tb_link_vq_multi;

  localparam int DW = 128;
  localparam int DEPTH = 8;
  localparam int NL = 4;
  localparam int CW = 4;
  localparam int LW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_vld;
  logic              wr_rdy;
  logic [LW-1:0]     wr_list;
  logic [DW-1:0]     wr_data;
  logic [LW-1:0]     rd_list;
  logic              rd_vld;
  logic              rd_rdy;
  logic [DW-1:0]     rd_data;
  logic              flush_vld;
  logic [LW-1:0]     flush_list;
  logic [NL-1:0]     list_empty;
  logic [NL*CW-1:0]  list_count;
  logic [CW-1:0]     free_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb [NL][$];

  always #5 clk = ~clk;

  link_vq_multi #(.DATAWIDTH(DW), .DEPTH(DEPTH), .NUM_LISTS(NL)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_vld     (wr_vld),
    .wr_rdy     (wr_rdy),
    .wr_list    (wr_list),
    .wr_data    (wr_data),
    .rd_list    (rd_list),
    .rd_vld     (rd_vld),
    .rd_rdy     (rd_rdy),
    .rd_data    (rd_data),
    .flush_vld  (flush_vld),
    .flush_list (flush_list),
    .list_empty (list_empty),
    .list_count (list_count),
    .free_count (free_count)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_free();
    int used = 0;
    for (int i = 0; i < NL; i++) used += sb[i].size();
    return DEPTH - used;
  endfunction

  task automatic check_state(input string tag);
    for (int i = 0; i < NL; i++) begin
      check($sformatf("%s count[%0d]", tag, i), DW'(list_count[i*CW +: CW]), DW'(sb[i].size()));
      check($sformatf("%s empty[%0d]", tag, i), DW'(list_empty[i]), DW'(sb[i].size() == 0));
    end
    check($sformatf("%s free_count", tag), DW'(free_count), DW'(model_free()));
  endtask

  // One clock cycle of stimulus. Inputs are driven just after a rising edge,
  // combinational outputs are checked before the next edge, and the model is
  // updated and compared against the registered state after it.
  task automatic cyc(input string tag,
                     input logic wv, input int wl, input logic [DW-1:0] wd,
                     input logic rv, input int rl,
                     input logic fv, input int fl);
    logic exp_wr_rdy, exp_rd_vld;
    wr_vld     = wv;
    wr_list    = LW'(wl);
    wr_data    = wd;
    rd_rdy     = rv;
    rd_list    = LW'(rl);
    flush_vld  = fv;
    flush_list = LW'(fl);
    #1;
    exp_wr_rdy = (model_free() != 0) && !fv;
    exp_rd_vld = (sb[rl].size() != 0) && !fv;
    check({tag, " wr_rdy"}, DW'(wr_rdy), DW'(exp_wr_rdy));
    check({tag, " rd_vld"}, DW'(rd_vld), DW'(exp_rd_vld));
    if (exp_rd_vld) check({tag, " rd_data"}, rd_data, sb[rl][0]);
    @(posedge clk);
    #1;
    if (fv) sb[fl].delete();
    if (rv && exp_rd_vld) void'(sb[rl].pop_front());
    if (wv && exp_wr_rdy) sb[wl].push_back(wd);
    wr_vld    = 1'b0;
    rd_rdy    = 1'b0;
    flush_vld = 1'b0;
    check_state(tag);
  endtask

  task automatic wr(input string tag, input int l, input logic [DW-1:0] d);
    cyc(tag, 1'b1, l, d, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic rd(input string tag, input int l);
    cyc(tag, 1'b0, 0, '0, 1'b1, l, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1; wr_vld = 1'b0; wr_list = '0; wr_data = '0;
    rd_list = '0; rd_rdy = 1'b0; flush_vld = 1'b0; flush_list = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("reset wr_rdy", DW'(wr_rdy), DW'(1));
    for (int l = 0; l < NL; l++) begin
      rd_list = LW'(l);
      #1 check($sformatf("reset rd_vld[%0d]", l), DW'(rd_vld), DW'(0));
    end
    check_state("reset");

    // Ordering across lists
    wr("ord w0", 2, 'h11);
    wr("ord w1", 2, 'h22);
    wr("ord w2", 0, 'h33);
    check("ord count2", DW'(list_count[2*CW +: CW]), DW'(2));
    check("ord count0", DW'(list_count[0*CW +: CW]), DW'(1));
    rd("ord r0", 2);
    rd("ord r1", 2);
    rd("ord r2", 0);
    check("ord free", DW'(free_count), DW'(8));

    // Fill the store, then hold a ninth write against a full queue
    for (int i = 0; i < 8; i++) wr($sformatf("full w%0d", i), (i % 2 == 0) ? 1 : 3, DW'(i));
    check("full free", DW'(free_count), DW'(0));
    cyc("full hold", 1'b1, 1, DW'(8), 1'b0, 0, 1'b0, 0);
    cyc("full pop", 1'b1, 1, DW'(8), 1'b1, 1, 1'b0, 0);
    check("full pop free", DW'(free_count), DW'(1));
    wr("full w8", 1, DW'(8));
    check("full refill free", DW'(free_count), DW'(0));

    // Flush: list 3 and list 1 hold three entries each, two free slots
    rd("pre-flush r1", 1);
    rd("pre-flush r3", 3);
    cyc("flush empty", 1'b0, 0, '0, 1'b0, 0, 1'b1, 2);
    cyc("flush 3", 1'b1, 0, 'h99, 1'b1, 1, 1'b1, 3);
    check("flush count3", DW'(list_count[3*CW +: CW]), DW'(0));
    check("flush free", DW'(free_count), DW'(5));
    for (int i = 0; i < 5; i++) wr($sformatf("post-flush w%0d", i), 0, DW'('h40 + i));
    check("post-flush free", DW'(free_count), DW'(0));
    for (int i = 0; i < 3; i++) rd($sformatf("list1 intact r%0d", i), 1);
    for (int i = 0; i < 5; i++) rd($sformatf("list0 drain r%0d", i), 0);

    // Same-list write and pop while the list holds one entry
    wr("conc seed", 0, 'hA);
    cyc("conc both", 1'b1, 0, 'hB, 1'b1, 0, 1'b0, 0);
    check("conc count0", DW'(list_count[0*CW +: CW]), DW'(1));
    check("conc rd_data", rd_data, DW'('hB));
    check("conc free", DW'(free_count), DW'(7));
    rd("conc drain", 0);

    // Write and pop together with a single free slot left
    for (int i = 0; i < 7; i++) wr($sformatf("one-free w%0d", i), i % 3, DW'('h50 + i));
    cyc("one-free both", 1'b1, 3, 'h5F, 1'b1, 0, 1'b0, 0);
    wr("one-free reuse", 2, 'h60);
    for (int l = 0; l < NL; l++)
      for (int n = sb[l].size(); n > 0; n--) rd($sformatf("one-free drain l%0d", l), l);

    // Reset in the middle of traffic
    for (int i = 0; i < 6; i++) wr($sformatf("mid w%0d", i), i % 3, DW'('h70 + i));
    wr_vld = 1'b1; wr_list = 2'd1; wr_data = 'h7F; rd_list = 2'd0;
    #2 reset = 1'b1;
    #1;
    for (int l = 0; l < NL; l++) sb[l].delete();
    check("mid rd_vld", DW'(rd_vld), DW'(0));
    check("mid wr_rdy", DW'(wr_rdy), DW'(1));
    check_state("mid reset");
    @(posedge clk);
    #1 reset = 1'b0; wr_vld = 1'b0;
    check_state("mid release");
    wr("after w0", 2, 'hC1);
    wr("after w1", 2, 'hC2);
    wr("after w2", 1, 'hC3);
    rd("after r0", 2);
    rd("after r1", 1);
    rd("after r2", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
